// File: rtl/demux_1to16_sync.sv
// demux_1to16_sync
//
// Registered 1-to-16 demultiplexer. On every rising clk edge the data word is
// loaded into the output selected by sel. By default every other output is
// cleared on the same edge, so at most one output is nonzero at a time.
// Outputs change one cycle after data/sel are sampled. No input reaches an
// output without passing through a register.
//
// Configuration macro:
//   DEMUX_1TO16_HOLD_EN  When defined, outputs that are not selected keep their
//                        previous value instead of clearing. The one-hot
//                        property then no longer holds. Reset still clears
//                        all outputs.
//
// Parameters:
//   DATA_W     width of data and of each output y0..y15
//
// Ports:
//   clk        rising-edge clock, the only clock
//   rst        synchronous reset, active-high; clears all outputs
//   data       word to route
//   sel        destination index 0..15, unsigned
//   y0..y15    registered outputs; y[sel] = data from the previous edge,
//              all others 0 (or held when DEMUX_1TO16_HOLD_EN is defined)

module demux_1to16_sync #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic [DATA_W-1:0] y4,
    output logic [DATA_W-1:0] y5,
    output logic [DATA_W-1:0] y6,
    output logic [DATA_W-1:0] y7,
    output logic [DATA_W-1:0] y8,
    output logic [DATA_W-1:0] y9,
    output logic [DATA_W-1:0] y10,
    output logic [DATA_W-1:0] y11,
    output logic [DATA_W-1:0] y12,
    output logic [DATA_W-1:0] y13,
    output logic [DATA_W-1:0] y14,
    output logic [DATA_W-1:0] y15
);

    localparam int unsigned NumOut = 16;

    // The sixteen output registers. They are the only state in the block.
    logic [DATA_W-1:0] y_q [NumOut];
    logic [DATA_W-1:0] y_d [NumOut];

    // Next-state logic. Every output gets a default first: cleared in the
    // normal build, or kept at its current value in the hold build. The
    // selected output then takes the data word. sel is a full 4-bit index,
    // so all 16 codes map to a real output.
    always_comb begin
        for (int i = 0; i < NumOut; i++) begin
`ifdef DEMUX_1TO16_HOLD_EN
            y_d[i] = y_q[i];
`else
            y_d[i] = '0;
`endif
        end
        y_d[sel] = data;
    end

    // Reset wins over data/sel on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumOut; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumOut; i++) begin
                y_q[i] <= y_d[i];
            end
        end
    end

    assign y0  = y_q[0];
    assign y1  = y_q[1];
    assign y2  = y_q[2];
    assign y3  = y_q[3];
    assign y4  = y_q[4];
    assign y5  = y_q[5];
    assign y6  = y_q[6];
    assign y7  = y_q[7];
    assign y8  = y_q[8];
    assign y9  = y_q[9];
    assign y10 = y_q[10];
    assign y11 = y_q[11];
    assign y12 = y_q[12];
    assign y13 = y_q[13];
    assign y14 = y_q[14];
    assign y15 = y_q[15];

endmodule

// File: tb/tb_demux_1to16_sync.sv
module tb_demux_1to16_sync;

    logic        clk;
    logic        rst;
    logic        data;
    logic [3:0]  sel;
    logic [7:0]  data8;
    logic [3:0]  sel8;

    logic        y0, y1, y2, y3, y4, y5, y6, y7;
    logic        y8, y9, y10, y11, y12, y13, y14, y15;
    logic [7:0]  z0, z1, z2, z3, z4, z5, z6, z7;
    logic [7:0]  z8, z9, z10, z11, z12, z13, z14, z15;

    logic [15:0]  obs1;
    logic [127:0] obs8;

    int total;
    int bad;

    assign obs1 = {y15, y14, y13, y12, y11, y10, y9, y8, y7, y6, y5, y4, y3, y2, y1, y0};
    assign obs8 = {z15, z14, z13, z12, z11, z10, z9, z8, z7, z6, z5, z4, z3, z2, z1, z0};

    demux_1to16_sync #(.DATA_W(1)) dut (
        .clk(clk), .rst(rst), .data(data), .sel(sel),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .y8(y8), .y9(y9), .y10(y10), .y11(y11), .y12(y12), .y13(y13), .y14(y14),
        .y15(y15)
    );

    demux_1to16_sync #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .data(data8), .sel(sel8),
        .y0(z0), .y1(z1), .y2(z2), .y3(z3), .y4(z4), .y5(z5), .y6(z6), .y7(z7),
        .y8(z8), .y9(z9), .y10(z10), .y11(z11), .y12(z12), .y13(z13), .y14(z14),
        .y15(z15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic [15:0] exp);
        total++;
        assert (obs1 === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs1, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [127:0] exp);
        total++;
        assert (obs8 === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs8, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0]  prev;
        logic [127:0] e8;
        total = 0;
        bad   = 0;

        // Reset for two cycles with data=1, sel=5 applied.
        rst = 1'b1; data = 1'b1; sel = 4'd5;
        data8 = 8'hA5; sel8 = 4'd5;
        tick();
        check1("reset_edge1", 16'h0000);
        check8("reset8_edge1", 128'h0);
        tick();
        check1("reset_edge2", 16'h0000);

        // Walking select with data=1. Each new sel must not show before the edge.
        rst = 1'b0;
        prev = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            #1;
            check1($sformatf("walk1_pre_%0d", i), prev);
            tick();
            prev = 16'h0001 << i;
            check1($sformatf("walk1_sel_%0d", i), prev);
        end

        // Walking select with data=0: nothing lights up.
        data = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            tick();
            check1($sformatf("walk0_sel_%0d", i), 16'h0000);
        end

        // Latency: sel 3 -> 12 with data=1.
        data = 1'b1; sel = 4'd3;
        tick();
        check1("lat_sel3", 16'h0008);
        sel = 4'd12;
        #2;
        check1("lat_sel12_before_edge", 16'h0008);
        tick();
        check1("lat_sel12_after_edge", 16'h1000);

        // Reset mid-stream with data=1, sel=7 steady.
        sel = 4'd7;
        tick();
        check1("mid_sel7", 16'h0080);
        rst = 1'b1;
        tick();
        check1("mid_rst", 16'h0000);
        rst = 1'b0;
        tick();
        check1("mid_resume", 16'h0080);

        // Hold-feature sequence: (1,2), (1,9), (0,2).
        data = 1'b1; sel = 4'd2;
        tick();
        check1("hold_step1", 16'h0004);
        sel = 4'd9;
        tick();
`ifdef DEMUX_1TO16_HOLD_EN
        check1("hold_step2", 16'h0204);
`else
        check1("hold_step2", 16'h0200);
`endif
        data = 1'b0; sel = 4'd2;
        tick();
`ifdef DEMUX_1TO16_HOLD_EN
        check1("hold_step3", 16'h0200);
`else
        check1("hold_step3", 16'h0000);
`endif

        // Wide instance: the whole word goes to the selected output.
        data8 = 8'hA5; sel8 = 4'd0;
        tick();
        e8 = 128'h0;
        e8[7:0] = 8'hA5;
        check8("wide_sel0", e8);
        data8 = 8'h3C; sel8 = 4'd15;
        tick();
        e8 = 128'h0;
`ifdef DEMUX_1TO16_HOLD_EN
        e8[7:0] = 8'hA5;
`endif
        e8[127:120] = 8'h3C;
        check8("wide_sel15", e8);
        data8 = 8'h81; sel8 = 4'd6;
        tick();
        e8 = 128'h0;
`ifdef DEMUX_1TO16_HOLD_EN
        e8[7:0] = 8'hA5;
        e8[127:120] = 8'h3C;
`endif
        e8[55:48] = 8'h81;
        check8("wide_sel6", e8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
